uart_tx_queue: RTL and testbench

//  Byte queue and launch controller directly upstream of the UART transmitter.
//  - Absorbs bursts of bytes written by the CPU/peripheral bus into a FIFO.
//  - Drives the transmitter's tx_send/Tx_Data pair one frame at a time.
//  - Paces itself from the transmitter's tx_state output, so the bus never polls per byte.

---
 rtl/uart_tx_queue_pkg.sv | 13 +
 rtl/uart_tx_queue_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_queue.sv | 111 +++++++++++
 tb/tb_uart_tx_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: launch FSM states and the
// default transmitter-idle encoding.
package uart_tx_queue_pkg;

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_LOAD = 2'd1,
    Q_WAIT = 2'd2
  } q_state_t;

  localparam logic [2:0] UART_TX_IDLE_ST = 3'd0;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// sync_fifo_param: single-clock FIFO with registered count/full/empty.
// Head of queue is presented combinationally on rd_data. Reused by the receive side.
module sync_fifo_param #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          wr_ok;
  logic          rd_ok;

  // Writes are gated by the registered full flag, pops by the registered empty flag.
  always_comb begin
    wr_ok     = wr_en && !full;
    rd_ok     = rd_en && !empty;
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array; no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at 2**AW; flags are registered from the next count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue and launch controller feeding the UART transmitter.
// Optional drain interrupt (irq_en/irq) is built when UART_TXQ_IRQ_EN is defined.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned AW         = 4,
  parameter logic [2:0]  TX_IDLE_ST = UART_TX_IDLE_ST
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  input  logic [2:0]  tx_state,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf,
  output logic        busy
`ifdef UART_TXQ_IRQ_EN
  ,
  input  logic        irq_en,
  output logic        irq
`endif
);

  q_state_t   state;
  q_state_t   state_nxt;
  logic       pop;
  logic       tx_idle;
  logic [7:0] head;

  sync_fifo_param #(
    .AW (AW),
    .DW (8)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign tx_idle = (tx_state == TX_IDLE_ST);

  // Launch FSM next-state: pop when idle with data, hold request until the
  // transmitter leaves idle, then wait for the frame to finish.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      Q_IDLE: begin
        if (!empty && tx_idle) begin
          pop       = 1'b1;
          state_nxt = Q_LOAD;
        end
      end
      Q_LOAD: begin
        if (!tx_idle) state_nxt = Q_WAIT;
      end
      Q_WAIT: begin
        if (tx_idle) state_nxt = Q_IDLE;
      end
      default: state_nxt = Q_IDLE;
    endcase
  end

  // State, launch request and the byte register presented to the transmitter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= Q_IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_nxt;
      tx_send <= (state_nxt == Q_LOAD);
      if (pop) tx_data <= head;
    end
  end

  // Sticky overflow: a dropped write outranks a simultaneous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign busy = !empty || (state != Q_IDLE);

`ifdef UART_TXQ_IRQ_EN
  // One-cycle drain pulse when the last frame finishes with nothing queued.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && (state == Q_WAIT) && tx_idle && empty;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue; the transmitter is emulated
// by driving tx_state by hand. Drain-irq steps build only with UART_TXQ_IRQ_EN.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic [2:0] tx_state;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UART_TXQ_IRQ_EN
  logic irq_en;
  logic irq;
  int   irq_cnt = 0;
  always @(posedge clk) if (irq === 1'b1) irq_cnt++;
`endif

  always #5 clk = ~clk;

  uart_tx_queue #(
    .AW         (4),
    .TX_IDLE_ST (3'd0)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx_state (tx_state),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .ovf      (ovf),
    .busy     (busy)
`ifdef UART_TXQ_IRQ_EN
    ,
    .irq_en   (irq_en),
    .irq      (irq)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Emulated transmitter: wait (bounded) for a launch, check the byte,
  // acknowledge for one cycle, then return to idle.
  task automatic serve(input logic [7:0] exp);
    for (int k = 0; k < 10 && tx_send !== 1'b1; k++) tick();
    chk("launch", {31'd0, tx_send}, 32'd1);
    chk("order", {24'd0, tx_data}, {24'd0, exp});
    tx_state = 3'd1;
    tick();
    tx_state = 3'd0;
    tick();
  endtask

  task automatic write1(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    n_rst    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    clr_ovf  = 1'b0;
    tx_state = 3'd0;
`ifdef UART_TXQ_IRQ_EN
    irq_en   = 1'b0;
`endif
    tick();
    tick();
    // Reset state
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_send", {31'd0, tx_send}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    n_rst = 1'b1;
    tick();

    // 1: single byte latency and hold
    write1(8'hA5);
    chk("t1_count1", {27'd0, count}, 32'd1);
    chk("t1_nosend", {31'd0, tx_send}, 32'd0);
    tick();
    chk("t1_send", {31'd0, tx_send}, 32'd1);
    chk("t1_data", {24'd0, tx_data}, 32'hA5);
    chk("t1_count0", {27'd0, count}, 32'd0);
    tick();
    tick();
    chk("t1_hold_send", {31'd0, tx_send}, 32'd1);
    chk("t1_hold_data", {24'd0, tx_data}, 32'hA5);
    tx_state = 3'd2;
    tick();
    chk("t1_ack_send", {31'd0, tx_send}, 32'd0);
    chk("t1_wait_busy", {31'd0, busy}, 32'd1);
    tx_state = 3'd0;
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: burst of 17 accepted bytes (1 in flight + 16 queued), 18th dropped
    for (int i = 1; i <= 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_count16", {27'd0, count}, 32'd16);
    chk("t2_inflight", {24'd0, tx_data}, 32'h01);
    chk("t2_noovf", {31'd0, ovf}, 32'd0);
    write1(8'h12);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_count_kept", {27'd0, count}, 32'd16);

    // 4: clear together with a drop keeps ovf; clear alone clears it
    wr_en   = 1'b1;
    wr_data = 8'h13;
    clr_ovf = 1'b1;
    tick();
    wr_en   = 1'b0;
    chk("t4_drop_wins", {31'd0, ovf}, 32'd1);
    tick();
    clr_ovf = 1'b0;
    chk("t4_cleared", {31'd0, ovf}, 32'd0);

    for (int i = 1; i <= 17; i++) serve(8'(i));
    chk("t2_drained", {31'd0, empty}, 32'd1);
    chk("t2_notbusy", {31'd0, busy}, 32'd0);

    // 3: simultaneous write and pop at count=3, pointers already past entry 15
    tx_state = 3'd1;
    write1(8'h21);
    write1(8'h22);
    write1(8'h23);
    chk("t3_count3", {27'd0, count}, 32'd3);
    tx_state = 3'd0;
    write1(8'h24);
    chk("t3_count_same", {27'd0, count}, 32'd3);
    chk("t3_head", {24'd0, tx_data}, 32'h21);
    serve(8'h21);
    serve(8'h22);
    serve(8'h23);
    serve(8'h24);
    chk("t3_empty", {31'd0, empty}, 32'd1);

    // 5: asynchronous reset while in Q_LOAD with 5 bytes queued
    tx_state = 3'd1;
    for (int i = 0; i < 6; i++) write1(8'h31 + 8'(i));
    tx_state = 3'd0;
    tick();
    chk("t5_count5", {27'd0, count}, 32'd5);
    chk("t5_load", {31'd0, tx_send}, 32'd1);
    #1;
    n_rst = 1'b0;
    #1;
    chk("t5_send_drop", {31'd0, tx_send}, 32'd0);
    chk("t5_count0", {27'd0, count}, 32'd0);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    tick();
    n_rst = 1'b1;
    tick();
    write1(8'h5A);
    tick();
    chk("t5_resume_send", {31'd0, tx_send}, 32'd1);
    serve(8'h5A);

`ifdef UART_TXQ_IRQ_EN
    // 6: drain interrupt, enabled then disabled
    irq_en  = 1'b1;
    tick();
    irq_cnt = 0;
    write1(8'h61);
    write1(8'h62);
    serve(8'h61);
    chk("t6_no_mid_irq", irq_cnt, 32'd0);
    serve(8'h62);
    tick();
    tick();
    chk("t6_one_irq", irq_cnt, 32'd1);
    irq_en  = 1'b0;
    irq_cnt = 0;
    write1(8'h63);
    write1(8'h64);
    serve(8'h63);
    serve(8'h64);
    tick();
    tick();
    chk("t6_masked", irq_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
